ws2812_serializer: RTL and testbench

Bit-level line driver for a WS2812 LED strip. It sits directly downstream of the fancy fader. It accepts one 8-bit colour segment per `trigger`/`data_request` handshake into a single-byte holding buffer. It shifts each byte out MSB first as WS2812 one-wire pulses, and holds the line low when out of data so the strip latches.

---
 rtl/ws2812_pkg.sv | 16 +
 rtl/ws2812_serializer_if.sv | 13 +
 rtl/ws2812_bit_timer.sv | 39 +++
 rtl/ws2812_serializer.sv | 118 +++++++++++
 tb/tb_ws2812_serializer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared timing defaults (12 MHz core clock) and state encoding for the WS2812 line driver.
package ws2812_pkg;

  localparam int DEF_T0H_CYCLES   = 4;
  localparam int DEF_T1H_CYCLES   = 8;
  localparam int DEF_BIT_CYCLES   = 15;
  localparam int DEF_RESET_CYCLES = 600;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ws2812_serializer_if.sv
// Byte handshake from the fader: level trigger with colour, combinational data_request
// acknowledges the capture edge; upstream holds the byte while data_request is low.
interface ws2812_serializer_if;
  import ws2812_pkg::*;

  logic  trigger;
  byte_t color;
  logic  data_request;

  modport master (output trigger, output color, input data_request);
  modport slave  (input trigger, input color, output data_request);

endinterface

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter: produces the combinational high phase and an end_of_bit strobe.
// Zero latency from cyc; restarts on start, idles at 0 while run is low.
module ws2812_bit_timer #(
  parameter int T0H_CYCLES = 4,
  parameter int T1H_CYCLES = 8,
  parameter int BIT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic bit_val,
  output logic high,
  output logic end_of_bit
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H_C = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_C = CW'(T1H_CYCLES);

  logic [CW-1:0] cyc;
  logic [CW-1:0] th;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= '0;
    end else if (start || !run || cyc == LAST) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + CW'(1);
    end
  end

  assign th         = bit_val ? T1H_C : T0H_C;
  assign high       = run && (cyc < th);
  assign end_of_bit = run && (cyc == LAST);

endmodule

// File: rtl/ws2812_serializer.sv
// WS2812 line driver: one-byte holding buffer, MSB-first shifter, two-state FSM.
// dout rises two edges after accept; data_request drops while the buffer is full.
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  ws2812_serializer_if.slave up,
  output logic              dout,
  output logic              busy,
  output logic              latched
);

  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(RESET_CYCLES);

  state_t        state, state_nxt;
  byte_t         buf_q;
  logic          buf_full, buf_full_nxt;
  byte_t         shifter;
  logic [2:0]    bit_idx;
  logic [LW-1:0] lat_cnt, lat_cnt_nxt;
  logic          accept, load;
  logic          line_high, end_of_bit;

  assign accept          = up.trigger && !buf_full;
  assign up.data_request = accept;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (buf_full) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Last bit of the byte: chain straight into the next one if it is waiting.
        if (end_of_bit && bit_idx == 3'd0) begin
          if (buf_full) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    buf_full_nxt = buf_full;
    if (load) begin
      buf_full_nxt = 1'b0;
    end else if (accept) begin
      buf_full_nxt = 1'b1;
    end
  end

  always_comb begin
    lat_cnt_nxt = '0;
    if (state == ST_IDLE && !load) begin
      lat_cnt_nxt = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + LW'(1);
    end
  end

  ws2812_bit_timer #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (load),
    .run        (state == ST_SHIFT),
    .bit_val    (shifter[bit_idx]),
    .high       (line_high),
    .end_of_bit (end_of_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      buf_q    <= '0;
      buf_full <= 1'b0;
      shifter  <= '0;
      bit_idx  <= '0;
      lat_cnt  <= '0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      latched  <= 1'b0;
    end else begin
      state    <= state_nxt;
      buf_full <= buf_full_nxt;
      lat_cnt  <= lat_cnt_nxt;
      dout     <= line_high;
      busy     <= (state_nxt == ST_SHIFT) || buf_full_nxt;
      latched  <= (lat_cnt_nxt == LAT_MAX);
      if (accept) begin
        buf_q <= up.color;
      end
      if (load) begin
        shifter <= buf_q;
        bit_idx <= 3'd7;
      end else if (end_of_bit && bit_idx != 3'd0) begin
        bit_idx <= bit_idx - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench: default-timing instance plus a scaled-timing instance, pulse monitor at negedge.
module tb_ws2812_serializer;
  import ws2812_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int total = 0;
  int bad   = 0;

  logic       trig   [2];
  logic [7:0] col    [2];
  logic       dreq   [2];
  logic       dout_w [2];
  logic       busy_w [2];
  logic       lat_w  [2];

  ws2812_serializer_if bus0 ();
  ws2812_serializer_if bus1 ();

  assign bus0.trigger = trig[0];
  assign bus0.color   = col[0];
  assign dreq[0]      = bus0.data_request;
  assign bus1.trigger = trig[1];
  assign bus1.color   = col[1];
  assign dreq[1]      = bus1.data_request;

  ws2812_serializer dut0 (
    .clk     (clk),
    .rst     (rst),
    .up      (bus0.slave),
    .dout    (dout_w[0]),
    .busy    (busy_w[0]),
    .latched (lat_w[0])
  );

  ws2812_serializer #(
    .T0H_CYCLES   (2),
    .T1H_CYCLES   (5),
    .BIT_CYCLES   (7),
    .RESET_CYCLES (10)
  ) dut1 (
    .clk     (clk),
    .rst     (rst),
    .up      (bus1.slave),
    .dout    (dout_w[1]),
    .busy    (busy_w[1]),
    .latched (lat_w[1])
  );

  // Pulse monitor: rise times, high widths and first latched rise per instance.
  int   rise_q  [2][$];
  int   width_q [2][$];
  int   hi_start[2] = '{0, 0};
  int   lat_rise[2] = '{-1, -1};
  logic prev_d  [2] = '{1'b0, 1'b0};
  logic prev_l  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dout_w[i] && !prev_d[i]) begin
        rise_q[i].push_back(cyc_cnt);
        hi_start[i] = cyc_cnt;
      end
      if (!dout_w[i] && prev_d[i]) width_q[i].push_back(cyc_cnt - hi_start[i]);
      if (lat_w[i] && !prev_l[i] && lat_rise[i] < 0) lat_rise[i] = cyc_cnt;
      prev_d[i] = dout_w[i];
      prev_l[i] = lat_w[i];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon(input int i);
    rise_q[i].delete();
    width_q[i].delete();
    lat_rise[i] = -1;
  endtask

  // Raise trigger, wait (bounded) for data_request, return the accept edge number.
  task automatic push(input int i, input logic [7:0] b, output int acc);
    int n;
    acc = -1;
    n = 0;
    trig[i] = 1'b1;
    col[i]  = b;
    #1;
    while (!dreq[i] && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("push_wait_bound", int'(n < 3000), 1);
    @(negedge clk);
    acc = cyc_cnt;
    trig[i] = 1'b0;
  endtask

  function automatic int width_errs(input int i, input logic [7:0] bq[$], input int t0, input int t1);
    int errs = 0;
    int k = 0;
    logic [7:0] b;
    foreach (bq[j]) begin
      b = bq[j];
      for (int bt = 7; bt >= 0; bt--) begin
        int e;
        e = b[bt] ? t1 : t0;
        if (k >= width_q[i].size() || width_q[i][k] != e) errs++;
        k++;
      end
    end
    return errs;
  endfunction

  function automatic int spacing_errs(input int i, input int bitc);
    int errs = 0;
    for (int k = 1; k < rise_q[i].size(); k++) begin
      if (rise_q[i][k] - rise_q[i][k-1] != bitc) errs++;
    end
    return errs;
  endfunction

  logic [7:0] exp_q[$];
  int acc, acc2, last;

  initial begin
    trig[0] = 1'b0; trig[1] = 1'b0;
    col[0]  = 8'h00; col[1]  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_dout", int'(dout_w[i]), 0);
      check("rst_busy", int'(busy_w[i]), 0);
      check("rst_latched", int'(lat_w[i]), 0);
      check("rst_dreq_lo", int'(dreq[i]), 0);
    end
    trig[0] = 1'b1; trig[1] = 1'b1;
    #1;
    check("rst_dreq_hi0", int'(dreq[0]), 1);
    check("rst_dreq_hi1", int'(dreq[1]), 1);
    trig[0] = 1'b0; trig[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycles(2);

    // Single byte 0xA5
    clear_mon(0);
    push(0, 8'hA5, acc);
    #1;
    check("a5_busy_after_accept", int'(busy_w[0]), 1);
    cycles(8 * 15 + 10);
    exp_q.delete(); exp_q.push_back(8'hA5);
    check("a5_pulse_count", rise_q[0].size(), 8);
    check("a5_widths", width_errs(0, exp_q, 4, 8), 0);
    check("a5_spacing", spacing_errs(0, 15), 0);
    check("a5_first_rise", rise_q[0].size() > 0 ? rise_q[0][0] : -1, acc + 2);
    cycles(600);
    last = rise_q[0].size() > 0 ? rise_q[0][rise_q[0].size()-1] : 0;
    check("a5_latch_time", lat_rise[0], last + 14 + 600);
    check("a5_idle_busy", int'(busy_w[0]), 0);
    check("a5_idle_dout", int'(dout_w[0]), 0);

    // Gapless stream of 24 bytes with a 4-cycle refill gap
    clear_mon(0);
    exp_q.delete();
    for (int j = 0; j < 24; j++) begin
      logic [7:0] b;
      b = 8'(j * 53 + 7);
      exp_q.push_back(b);
      push(0, b, acc);
      cycles(4);
    end
    check("stream_busy", int'(busy_w[0]), 1);
    cycles(900);
    check("stream_pulse_count", rise_q[0].size(), 192);
    check("stream_widths", width_errs(0, exp_q, 4, 8), 0);
    check("stream_spacing", spacing_errs(0, 15), 0);
    last = rise_q[0].size() > 0 ? rise_q[0][rise_q[0].size()-1] : 0;
    check("stream_latch_time", lat_rise[0], last + 14 + 600);
    check("stream_latched_now", int'(lat_w[0]), 1);

    // Backpressure: second byte waits while the buffer is full
    clear_mon(0);
    push(0, 8'h00, acc);
    trig[0] = 1'b1;
    col[0]  = 8'hFF;
    #1;
    check("bp_dreq_full", int'(dreq[0]), 0);
    @(negedge clk);
    #1;
    check("bp_dreq_load", int'(dreq[0]), 1);
    @(negedge clk);
    #1;
    check("bp_dreq_after", int'(dreq[0]), 0);
    trig[0] = 1'b0;
    cycles(16 * 15 + 10);
    exp_q.delete(); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    check("bp_pulse_count", rise_q[0].size(), 16);
    check("bp_widths", width_errs(0, exp_q, 4, 8), 0);
    check("bp_spacing", spacing_errs(0, 15), 0);
    check("bp_first_rise", rise_q[0].size() > 0 ? rise_q[0][0] : -1, acc + 2);

    // Reset mid-bit during a T1H high phase
    cycles(620);
    clear_mon(0);
    push(0, 8'hFF, acc);
    cycles(3);
    check("mid_pre_high", int'(dout_w[0]), 1);
    rst = 1'b0;
    #1;
    check("mid_dout_drop", int'(dout_w[0]), 0);
    check("mid_busy", int'(busy_w[0]), 0);
    check("mid_latched", int'(lat_w[0]), 0);
    check("mid_dreq_lo", int'(dreq[0]), 0);
    trig[0] = 1'b1;
    col[0]  = 8'h80;
    #1;
    check("mid_dreq_hi", int'(dreq[0]), 1);
    repeat (2) @(negedge clk);
    clear_mon(0);
    rst = 1'b1;
    @(negedge clk);
    acc = cyc_cnt;
    #1;
    check("mid_first_edge_accept", int'(dreq[0]), 0);
    trig[0] = 1'b0;
    cycles(8 * 15 + 10);
    exp_q.delete(); exp_q.push_back(8'h80);
    check("mid_pulse_count", rise_q[0].size(), 8);
    check("mid_widths", width_errs(0, exp_q, 4, 8), 0);
    check("mid_first_rise", rise_q[0].size() > 0 ? rise_q[0][0] : -1, acc + 2);

    // Scaled timing instance: T0H=2, T1H=5, BIT=7, RESET=10
    cycles(20);
    clear_mon(1);
    push(1, 8'hA5, acc);
    cycles(4);
    push(1, 8'h3C, acc2);
    cycles(150);
    exp_q.delete(); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    check("sw_pulse_count", rise_q[1].size(), 16);
    check("sw_widths", width_errs(1, exp_q, 2, 5), 0);
    check("sw_spacing", spacing_errs(1, 7), 0);
    check("sw_first_rise", rise_q[1].size() > 0 ? rise_q[1][0] : -1, acc + 2);
    last = rise_q[1].size() > 0 ? rise_q[1][rise_q[1].size()-1] : 0;
    check("sw_latch_time", lat_rise[1], last + 6 + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
